// File: rtl/free_list_pkg.sv
// free_list_pkg: shared defaults and types for the physical-register free list
package free_list_pkg;
   localparam int DEF_N          = 3;
   localparam int DEF_ARCH_COUNT = 32;
   localparam int DEF_PHYS_REGS  = 64;
   typedef logic [$clog2(DEF_PHYS_REGS)-1:0] PHYS_TAG;
   typedef logic [DEF_PHYS_REGS-1:0]         FREE_BITMAP;
endpackage

// File: rtl/free_list_picker.sv
// free_list_picker: in-order grant of the lowest set bitmap indices to requesting lanes (lane N-1 oldest)
module free_list_picker #(
   parameter int N  = 3,
   parameter int W  = 64,
   localparam int TW = $clog2(W)
) (
   input  logic [W-1:0]          bitmap,
   input  logic [N-1:0]          req,
   output logic [N-1:0]          grant,
   output logic [N-1:0][TW-1:0]  idx
);
   logic [W-1:0]  rem;
   logic          stop;
   logic          found;
   logic [TW-1:0] pick;
   // oldest lane first; an unserved requester blocks every younger lane
   always_comb begin
      rem   = bitmap;
      stop  = 1'b0;
      found = 1'b0;
      pick  = '0;
      grant = '0;
      idx   = '0;
      for (int l = N - 1; l >= 0; l--) begin
         found = 1'b0;
         pick  = '0;
         for (int b = W - 1; b >= 0; b--)
            if (rem[b]) begin
               found = 1'b1;
               pick  = TW'(b);
            end
         if (req[l] && !stop) begin
            if (found) begin
               grant[l]  = 1'b1;
               idx[l]    = pick;
               rem[pick] = 1'b0;
            end else
               stop = 1'b1;
         end
      end
   end
endmodule

// File: rtl/free_list.sv
// free_list: R10K speculative/architectural free bitmaps; FREELIST_FREE_BYPASS_EN lets same-cycle frees be granted
module free_list
   import free_list_pkg::*;
#(
   parameter int N          = DEF_N,
   parameter int ARCH_COUNT = DEF_ARCH_COUNT,
   parameter int PHYS_REGS  = DEF_PHYS_REGS,
   localparam int PRW = $clog2(PHYS_REGS),
   localparam int CW  = $clog2(PHYS_REGS + 1)
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [N-1:0]           allocReq,
   output logic [N-1:0]           allocGrant,
   output logic [N-1:0][PRW-1:0]  allocTags,
   input  logic [PHYS_REGS-1:0]   freeMask,
   input  logic [N-1:0]           archWriteEnables,
   input  logic [N-1:0][PRW-1:0]  archWritePhysRegs,
   input  logic                   recover,
   output logic [CW-1:0]          freeCount,
   output logic                   allocStall
);
   localparam logic [PHYS_REGS-1:0] RST_MAP = {{(PHYS_REGS - ARCH_COUNT){1'b1}}, {ARCH_COUNT{1'b0}}};
   localparam logic [PHYS_REGS-1:0] KEEP    = {{(PHYS_REGS - 1){1'b1}}, 1'b0};
   logic [PHYS_REGS-1:0] spec_free, arch_free, free_in, scan, grant_mask, commit_mask, arch_nxt, spec_nxt;
   logic [N-1:0]         req_eff;
   logic [CW-1:0]        cnt_nxt;
   assign free_in = freeMask & KEEP;
   assign req_eff = recover ? '0 : allocReq;
`ifdef FREELIST_FREE_BYPASS_EN
   assign scan     = spec_free | free_in;
   assign spec_nxt = recover ? arch_nxt : scan & ~grant_mask;
`else
   assign scan     = spec_free;
   assign spec_nxt = recover ? arch_nxt : (spec_free & ~grant_mask) | free_in;
`endif
   assign arch_nxt   = (arch_free | free_in) & ~commit_mask & KEEP;
   assign allocStall = |(allocReq & ~allocGrant);
   free_list_picker #(.N(N), .W(PHYS_REGS)) u_picker (
      .bitmap (scan),
      .req    (req_eff),
      .grant  (allocGrant),
      .idx    (allocTags)
   );
   // one-hot masks of PRs handed to rename and PRs becoming architecturally mapped
   always_comb begin
      grant_mask  = '0;
      commit_mask = '0;
      for (int l = 0; l < N; l++) begin
         if (allocGrant[l]) grant_mask[allocTags[l]] = 1'b1;
         if (archWriteEnables[l]) commit_mask[archWritePhysRegs[l]] = 1'b1;
      end
   end
   // population count of the next speculative bitmap, registered as freeCount
   always_comb begin
      cnt_nxt = '0;
      for (int b = 0; b < PHYS_REGS; b++) cnt_nxt = cnt_nxt + CW'(spec_nxt[b]);
   end
   // bitmap and count registers; reset wins over every other input
   always_ff @(posedge clock) begin
      if (reset) begin
         spec_free <= RST_MAP;
         arch_free <= RST_MAP;
         freeCount <= CW'(PHYS_REGS - ARCH_COUNT);
      end else begin
         spec_free <= spec_nxt;
         arch_free <= arch_nxt;
         freeCount <= cnt_nxt;
      end
   end
endmodule

// File: tb/tb_free_list.sv
// tb_free_list: randomized and directed checks of free_list against a queue-based reference model
module tb_free_list;
   import free_list_pkg::*;
   logic            clk = 1'b0;
   logic            rst;
   logic [2:0]      req, gr, awe;
   logic [2:0][5:0] tags, awp;
   FREE_BITMAP      fm;
   logic            rec, stall;
   logic [6:0]      cnt;
   FREE_BITMAP      m_spec, m_arch;
   logic [2:0]      e_gr;
   PHYS_TAG         e_tag [3];
   int              checks = 0, errors = 0;
   localparam FREE_BITMAP RST_MAP = {{32{1'b1}}, {32{1'b0}}};

   free_list dut (
      .clock(clk), .reset(rst), .allocReq(req), .allocGrant(gr), .allocTags(tags),
      .freeMask(fm), .archWriteEnables(awe), .archWritePhysRegs(awp), .recover(rec),
      .freeCount(cnt), .allocStall(stall)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_alloc();
      int q[$];
      bit stop = 0;
      FREE_BITMAP cand = m_spec;
`ifdef FREELIST_FREE_BYPASS_EN
      cand = cand | (fm & ~64'd1);
`endif
      for (int b = 0; b < 64; b++) if (cand[b]) q.push_back(b);
      e_gr = '0;
      for (int l = 0; l < 3; l++) e_tag[l] = '0;
      if (!rec)
         for (int l = 2; l >= 0; l--)
            if (req[l] && !stop) begin
               if (q.size() > 0) begin
                  e_gr[l]  = 1'b1;
                  e_tag[l] = PHYS_TAG'(q.pop_front());
               end else stop = 1;
            end
   endtask

   task automatic drive(input logic [2:0] r, input FREE_BITMAP f, input logic [2:0] we,
                        input logic [2:0][5:0] wp, input logic rc, input logic rs);
      req = r; fm = f; awe = we; awp = wp; rec = rc; rst = rs;
      #1;
      model_alloc();
      check("grant", 64'(gr), 64'(e_gr));
      for (int l = 0; l < 3; l++) check($sformatf("tag%0d", l), 64'(tags[l]), 64'(e_tag[l]));
      check("stall", 64'(stall), 64'(|(r & ~e_gr)));
      check("freeCount", 64'(cnt), 64'($countones(m_spec)));
   endtask

   task automatic tick();
      FREE_BITMAP fin, an, gm;
      @(posedge clk);
      if (rst) begin
         m_spec = RST_MAP;
         m_arch = RST_MAP;
      end else begin
         fin = fm & ~64'd1;
         an  = m_arch | fin;
         for (int w = 0; w < 3; w++) if (awe[w]) an[awp[w]] = 1'b0;
         an[0] = 1'b0;
         gm = '0;
         for (int l = 0; l < 3; l++) if (e_gr[l]) gm[e_tag[l]] = 1'b1;
`ifdef FREELIST_FREE_BYPASS_EN
         m_spec = rec ? an : (m_spec | fin) & ~gm;
`else
         m_spec = rec ? an : (m_spec & ~gm) | fin;
`endif
         m_arch = an;
      end
      @(negedge clk);
   endtask

   task automatic cyc(input logic [2:0] r, input FREE_BITMAP f = '0, input logic [2:0] we = '0,
                      input logic [2:0][5:0] wp = '0, input logic rc = 0, input logic rs = 0);
      drive(r, f, we, wp, rc, rs);
      tick();
   endtask

   initial begin
      FREE_BITMAP one = 64'd1;
      logic [2:0][5:0] wp;
      req = '0; fm = '0; awe = '0; awp = '0; rec = 0; rst = 1;
      @(negedge clk);
      m_spec = '0; m_arch = '0; e_gr = '0;
      tick();
      // reset state and first allocation
      drive(3'b111, '0, '0, '0, 0, 0);
      check("rst_count", 64'(cnt), 64'd32);
      check("first_lane2", 64'(tags[2]), 64'd32);
      check("first_lane0", 64'(tags[0]), 64'd34);
      tick();
      check("count_after_first", 64'(cnt), 64'd29);
      // drain down to a single free PR
      for (int i = 0; i < 9; i++) cyc(3'b111);
      cyc(3'b001);
      drive(3'b111, '0, '0, '0, 0, 0);
      check("drain_grant", 64'(gr), 64'b100);
      check("drain_stall", 64'(stall), 64'd1);
      check("drain_tag1", 64'(tags[1]), 64'd0);
      tick();
      // free PR50 while it is the only candidate
      drive(3'b001, one << 50, '0, '0, 0, 0);
`ifdef FREELIST_FREE_BYPASS_EN
      check("bypass_same", 64'(gr), 64'b001);
`else
      check("nobypass_same", 64'(gr), 64'b000);
`endif
      tick();
      drive(3'b001, '0, '0, '0, 0, 0);
`ifndef FREELIST_FREE_BYPASS_EN
      check("nobypass_next_tag", 64'(tags[0]), 64'd50);
`endif
      tick();
      // commit, allocate, then recover
      cyc(3'b000, '0, '0, '0, 0, 1);
      wp = '0; wp[0] = 6'd32;
      cyc(3'b111, one << 5, 3'b001, wp);
      cyc(3'b111);
      cyc(3'b111);
      cyc(3'b001);
      drive(3'b111, '0, '0, '0, 1, 0);
      check("recover_grant", 64'(gr), 64'd0);
      tick();
      drive(3'b111, '0, '0, '0, 0, 0);
      check("post_rec_count", 64'(cnt), 64'd32);
      check("post_rec_lane2", 64'(tags[2]), 64'd5);
      check("post_rec_lane1", 64'(tags[1]), 64'd33);
      tick();
      // reset concurrent with everything
      cyc(3'b111, one << 40 | one << 7, 3'b011, wp, 1, 1);
      drive(3'b111, '0, '0, '0, 0, 0);
      check("rst_mid_count", 64'(cnt), 64'd32);
      check("rst_mid_lane2", 64'(tags[2]), 64'd32);
      // PR0 and double free
      drive(3'b000, one | one << 40, '0, '0, 0, 0);
      tick();
      check("dup_count", 64'(cnt), 64'd32);
      drive(3'b000, '0, '0, '0, 0, 0);
      tick();
      // random traffic
      for (int i = 0; i < 400; i++) begin
         FREE_BITMAP f = '0;
         logic [2:0] we;
         if ($urandom_range(0, 2) == 0) f[$urandom_range(0, 63)] = 1'b1;
         if ($urandom_range(0, 4) == 0) f[$urandom_range(0, 63)] = 1'b1;
         we = 3'($urandom);
         for (int l = 0; l < 3; l++) wp[l] = 6'($urandom);
         cyc(3'($urandom), f, we, wp, $urandom_range(0, 29) == 0, $urandom_range(0, 199) == 0);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
